// File: rtl/sram_dma_engine.sv
// Word-granular copy/fill DMA initiator driving one active-low SRAM_wrapper port.
// Copy alternates READ/WRITE per word; fill streams WRITEs; abort or misalignment ends with err.
module sram_dma_engine #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [31:0]   src_addr,
    input  logic [31:0]   dst_addr,
    input  logic [15:0]   len,
    input  logic [DW-1:0] fill_data,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   words_done,
    output logic          CEB,
    output logic          WEB,
    output logic [DW-1:0] BWEB,
    output logic [AW-1:0] A,
    output logic [DW-1:0] DI,
    input  logic [DW-1:0] DO,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [15:0]   rem_q, rem_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          err_q, err_d;
    logic [15:0]   wd_q, wd_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] di_q, di_d;

    // SRAM port is a pure decode of registered state; A/DI hold their last driven value when idle.
    always_comb begin
        CEB  = 1'b1;
        WEB  = 1'b1;
        BWEB = '1;
        A    = a_q;
        DI   = di_q;
        case (state_q)
            S_READ: begin
                CEB = 1'b0;
                A   = src_q;
            end
            S_WRITE: begin
                CEB  = 1'b0;
                WEB  = 1'b0;
                BWEB = '0;
                A    = dst_q;
                DI   = mode_q ? fill_q : buf_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        err_d   = err_q;
        wd_d    = wd_q;
        a_d     = A;
        di_d    = DI;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    fill_d = fill_data;
                    src_d  = src_addr[AW+1:2];
                    dst_d  = dst_addr[AW+1:2];
                    rem_d  = len;
                    wd_d   = 16'd0;
                    err_d  = 1'b0;
                    if (dst_addr[1:0] != 2'b00 || (!mode && src_addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (len == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = mode ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    buf_d   = DO;
                    src_d   = src_q + AW'(1);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write of this cycle is already issued, so it counts even when aborted.
                dst_d = dst_q + AW'(1);
                wd_d  = wd_q + 16'd1;
                rem_d = rem_q - 16'd1;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (rem_q == 16'd1) begin
                    state_d = S_DONE;
                end else begin
                    state_d = mode_q ? S_WRITE : S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= 16'd0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= 16'd0;
            a_q     <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            a_q     <= a_d;
            di_q    <= di_d;
        end
    end

    assign busy       = (state_q == S_READ) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_DONE) && err_q;
    assign words_done = wd_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram_dma_engine.sv
// Bench for sram_dma_engine: SRAM model on the inverted clock, a word-level transfer model,
// table-driven directed transfers, abort/reset sequences and randomized transfers.
module tb_sram_dma_engine;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [31:0]   dst_addr = '0;
    logic [15:0]   len = '0;
    logic [DW-1:0] fill_data = '0;
    logic          abort = 1'b0;
    logic          busy, done, err, CEB, WEB;
    logic [15:0]   words_done;
    logic [DW-1:0] BWEB, DI;
    logic [DW-1:0] DO = '0;
    logic [AW-1:0] A;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    sram_dma_engine #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .fill_data(fill_data), .abort(abort),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO),
        .dbg_state(dbg_state)
    );

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] exp_mem [NW];
    logic [AW-1:0] wr_log [$];
    logic [AW-1:0] exp_q [$];

    // SRAM responder clocked on the falling edge, so DO is settled at the rising edge ending READ.
    always @(negedge clk) begin
        if (!CEB) begin
            if (!WEB) begin
                mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
                wr_log.push_back(A);
            end else begin
                DO <= mem[A];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Word-level reference: a transfer is an ascending list of word moves, truncated by abort.
    task automatic model(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] l, input logic [31:0] f, input int abort_w,
                         output logic e, output int wd, output int busy_n, output int lat);
        logic [AW-1:0] sw, dw;
        int n;
        exp_q.delete();
        if (d[1:0] != 2'b00 || (!m && s[1:0] != 2'b00)) begin
            e = 1'b1; wd = 0; busy_n = 0; lat = 1;
            return;
        end
        n = int'(l);
        e = 1'b0;
        if (abort_w > 0 && abort_w <= n) begin
            n = abort_w;
            e = 1'b1;
        end
        sw = s[AW+1:2];
        dw = d[AW+1:2];
        for (int i = 0; i < n; i++) begin
            exp_mem[dw] = m ? f : exp_mem[sw];
            exp_q.push_back(dw);
            sw = sw + AW'(1);
            dw = dw + AW'(1);
        end
        wd = n;
        busy_n = m ? n : 2 * n;
        lat = busy_n + 1;
    endtask

    // Runs one transfer; cycle c=1 is the cycle right after the edge that samples start.
    task automatic do_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] l, input logic [31:0] f, input int abort_w,
                           input bit poke, output int busy_n, output int lat, output logic e,
                           output logic [15:0] wd, output logic acc, output bit timed_out);
        int writes;
        writes = 0; busy_n = 0; lat = 0; e = 1'b0; wd = '0; acc = 1'b0; timed_out = 1'b1;
        wr_log.delete();
        @(posedge clk); #1;
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 200; c++) begin
            start = 1'b0;
            abort = 1'b0;
            if (busy) busy_n++;
            if (!CEB) acc = 1'b1;
            if (done) begin
                e = err; wd = words_done; lat = c; timed_out = 1'b0;
                break;
            end
            if (!CEB && !WEB) begin
                writes++;
                if (writes == abort_w) abort = 1'b1;
            end
            if (poke && c == 1) begin
                start = 1'b1; mode = ~m; dst_addr = 32'h0; src_addr = 32'h0; len = 16'd5;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk({name, "_mem"}, bad, 0);
        chk({name, "_wr_count"}, wr_log.size(), exp_q.size());
        if (wr_log.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++) chk({name, "_wr_order"}, wr_log[i], exp_q[i]);
    endtask

    typedef struct {
        logic        m;
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] l;
        logic [31:0] f;
        int          abort_w;
        bit          poke;
        logic        exp_err;
        int          exp_wd;
        int          exp_busy;
        int          exp_lat;
    } vec_t;

    task automatic apply(input string name, input vec_t v, input bit use_model);
        logic me, e, acc;
        int mwd, mb, ml, busy_n, lat;
        logic [15:0] wd;
        bit to;
        model(v.m, v.s, v.d, v.l, v.f, v.abort_w, me, mwd, mb, ml);
        if (use_model) begin
            v.exp_err = me; v.exp_wd = mwd; v.exp_busy = mb; v.exp_lat = ml;
        end
        do_xfer(v.m, v.s, v.d, v.l, v.f, v.abort_w, v.poke, busy_n, lat, e, wd, acc, to);
        chk({name, "_timeout"}, to, 0);
        chk({name, "_err"}, e, v.exp_err);
        chk({name, "_words_done"}, wd, v.exp_wd);
        chk({name, "_busy_cycles"}, busy_n, v.exp_busy);
        chk({name, "_done_latency"}, lat, v.exp_lat);
        chk({name, "_sram_access"}, acc, (v.exp_wd > 0) || (v.exp_busy > 0));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_idle"}, dbg_state, 0);
        chk({name, "_wd_hold"}, words_done, v.exp_wd);
        mem_check(name);
    endtask

    vec_t tbl[7];

    initial begin
        logic [DW-1:0] v;
        logic e, acc;
        int busy_n, lat, mwd, mb, ml;
        logic [15:0] wd;
        vec_t rv;

        tbl[0] = '{1'b0, 32'h100,  32'h200, 16'd4, 32'h0,        0, 1'b0, 1'b0, 4, 8, 9};
        tbl[1] = '{1'b1, 32'h0,    32'h10,  16'd3, 32'hDEADBEEF, 0, 1'b0, 1'b0, 3, 3, 4};
        tbl[2] = '{1'b1, 32'h0,    32'h20,  16'd0, 32'h11111111, 0, 1'b0, 1'b0, 0, 0, 1};
        tbl[3] = '{1'b0, 32'h100,  32'h202, 16'd4, 32'h0,        0, 1'b0, 1'b1, 0, 0, 1};
        tbl[4] = '{1'b1, 32'h0,    32'hFFFC, 16'd2, 32'h12345678, 0, 1'b0, 1'b0, 2, 2, 3};
        tbl[5] = '{1'b0, 32'h400,  32'h600, 16'd8, 32'h0,        3, 1'b1, 1'b1, 3, 6, 7};
        tbl[6] = '{1'b0, 32'h101,  32'h300, 16'd2, 32'h0,        0, 1'b0, 1'b1, 0, 0, 1};

        for (int i = 0; i < NW; i++) begin
            v = $urandom;
            mem[i] = v;
            exp_mem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            mem[16'h40 + i] = 32'hA0 + i;
            exp_mem[16'h40 + i] = 32'hA0 + i;
        end

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words_done", words_done, 0);
        chk("rst_ceb", CEB, 1);
        chk("rst_web", WEB, 1);
        chk("rst_bweb", BWEB, 32'hFFFFFFFF);
        chk("rst_a", A, 0);
        chk("rst_di", DI, 0);
        chk("rst_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply($sformatf("vec%0d", i), tbl[i], 1'b0);
            if (i == 0)
                for (int j = 0; j < 4; j++) chk("copy_data", mem[16'h80 + j], 32'hA0 + j);
            if (i == 4) begin
                chk("wrap_a_hold", A, 0);
                chk("wrap_di_hold", DI, 32'h12345678);
            end
        end

        // Reset in the middle of a fill: three words land before rst drops.
        wr_log.delete();
        @(posedge clk); #1;
        mode = 1'b1; dst_addr = 32'h800; len = 16'd10; fill_data = 32'h55AA55AA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ceb", CEB, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_words_done", words_done, 0);
        chk("mid_rst_state", dbg_state, 0);
        model(1'b1, 32'h0, 32'h800, 16'd3, 32'h55AA55AA, 0, e, mwd, mb, ml);
        mem_check("mid_rst");
        @(posedge clk); #1 rst = 1'b1;
        rv = '{1'b1, 32'h0, 32'h900, 16'd1, 32'hCAFEF00D, 0, 1'b0, 1'b0, 1, 1, 2};
        apply("post_rst", rv, 1'b0);

        for (int k = 0; k < 24; k++) begin
            rv.m = 1'($urandom_range(0, 1));
            rv.s = 32'($urandom_range(0, NW - 1)) << 2;
            if ($urandom_range(0, 3) == 0) rv.d = rv.s + (32'($urandom_range(0, 3)) << 2);
            else rv.d = 32'($urandom_range(0, NW - 1)) << 2;
            if ($urandom_range(0, 7) == 0) rv.d[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rv.s[1:0] = 2'($urandom_range(1, 3));
            rv.l = 16'($urandom_range(0, 10));
            rv.f = $urandom;
            rv.abort_w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            rv.poke = 1'($urandom_range(0, 1));
            apply($sformatf("rnd%0d", k), rv, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
